// File: rtl/harmonic_mixer_if.sv
// Bundles the harmonic-stage samples, transport controls and codec-side mix outputs
// of harmonic_mixer into one port.
interface harmonic_mixer_if;
    logic               play_enable;
    logic               note_done;
    logic               generate_next_sample;
    logic [2:0]         harm_en;
    logic signed [15:0] harm0_in;
    logic signed [15:0] harm1_in;
    logic signed [15:0] harm2_in;
    logic               harm0_ready;
    logic               harm1_ready;
    logic               harm2_ready;
    logic signed [15:0] mix_out;
    logic               mix_ready;
    logic               timeout_err;
    logic               overrun;

    modport master (
        output play_enable, note_done, generate_next_sample, harm_en,
        output harm0_in, harm1_in, harm2_in, harm0_ready, harm1_ready, harm2_ready,
        input  mix_out, mix_ready, timeout_err, overrun
    );

    modport slave (
        input  play_enable, note_done, generate_next_sample, harm_en,
        input  harm0_in, harm1_in, harm2_in, harm0_ready, harm1_ready, harm2_ready,
        output mix_out, mix_ready, timeout_err, overrun
    );
endinterface

// File: rtl/harmonic_mixer.sv
// Sums one sample from each enabled harmonic per codec request into a 16-bit mix sample.
// Define MIX_SATURATE_EN for the louder sum>>>1 mix with clamping; default is sum>>>2.
module harmonic_mixer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input logic             clk,
    input logic             reset,
    harmonic_mixer_if.slave bus
);

    // state   | meaning
    // IDLE    | waiting for generate_next_sample with play_enable high
    // COLLECT | latching harmonic samples until all enabled ones arrive or timeout
    // SUM     | registering the 18-bit sum of captured samples
    // OUTPUT  | publishing the scaled mix and pulsing mix_ready
    typedef enum logic [1:0] {IDLE, COLLECT, SUM, OUTPUT} state_t;

    state_t             state;
    state_t             state_next;
    logic [2:0]         got;
    logic [CNT_W-1:0]   cnt;
    logic signed [15:0] cap [3];
    logic signed [17:0] sum_r;
    logic               to_flag;

    logic signed [15:0] harm_in [3];
    logic signed [17:0] term [3];
    logic [2:0]         hit;
    logic               all_done;
    logic               expire;
    logic               abort;
    logic signed [15:0] mix_scaled;

    always_comb begin
        harm_in[0] = bus.harm0_in;
        harm_in[1] = bus.harm1_in;
        harm_in[2] = bus.harm2_in;
        hit        = {bus.harm2_ready, bus.harm1_ready, bus.harm0_ready} & bus.harm_en;
        all_done   = &(got | hit | ~bus.harm_en);
        expire     = (cnt == CNT_W'(TIMEOUT - 1));
        abort      = bus.note_done | ~bus.play_enable;
        for (int n = 0; n < 3; n++) begin
            term[n] = got[n] ? {{2{cap[n][15]}}, cap[n]} : '0;
        end
    end

`ifdef MIX_SATURATE_EN
    logic signed [17:0] half;

    always_comb begin
        half = sum_r >>> 1;
        if (half > 18'sd32767)
            mix_scaled = 16'sh7fff;
        else if (half < -18'sd32768)
            mix_scaled = 16'sh8000;
        else
            mix_scaled = half[15:0];
    end
`else
    // Three 16-bit samples quartered always fit, so the low 16 bits are exact.
    always_comb begin
        mix_scaled = 16'(sum_r >>> 2);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.generate_next_sample) state_next = COLLECT;
                COLLECT: if (all_done || expire) state_next = SUM;
                SUM:     state_next = OUTPUT;
                OUTPUT:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            got             <= '0;
            cnt             <= '0;
            cap[0]          <= '0;
            cap[1]          <= '0;
            cap[2]          <= '0;
            sum_r           <= '0;
            to_flag         <= 1'b0;
            bus.mix_out     <= '0;
            bus.mix_ready   <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.overrun     <= 1'b0;
        end else begin
            bus.mix_ready   <= 1'b0;
            bus.timeout_err <= 1'b0;
            bus.overrun     <= bus.generate_next_sample && (state != IDLE);
            if (bus.note_done) begin
                bus.mix_out <= '0;
            end else if (bus.play_enable) begin
                case (state)
                    IDLE: begin
                        if (bus.generate_next_sample) begin
                            got     <= '0;
                            cnt     <= '0;
                            to_flag <= 1'b0;
                        end
                    end
                    COLLECT: begin
                        for (int n = 0; n < 3; n++) begin
                            if (hit[n]) begin
                                cap[n] <= harm_in[n];
                                got[n] <= 1'b1;
                            end
                        end
                        cnt     <= cnt + CNT_W'(1);
                        to_flag <= expire & ~all_done;
                    end
                    SUM: begin
                        sum_r <= term[0] + term[1] + term[2];
                    end
                    OUTPUT: begin
                        bus.mix_out     <= mix_scaled;
                        bus.mix_ready   <= 1'b1;
                        bus.timeout_err <= to_flag;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_harmonic_mixer.sv
// Scoreboard bench for harmonic_mixer: a transaction-level model predicts each mix
// (value, timeout flag, completion cycle) and a monitor checks every mix_ready.
module tb_harmonic_mixer;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    harmonic_mixer_if bus();

    harmonic_mixer #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int val;
        bit terr;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_out = 0;
    int         g_cyc;
    logic [2:0] en_m;
    int         fd[3];
    int         fv[3];
    int         sd[3];
    int         sv[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int scale(input int s);
        int h;
`ifdef MIX_SATURATE_EN
        h = s >>> 1;
        if (h > 32767) h = 32767;
        else if (h < -32768) h = -32768;
        return h;
`else
        logic signed [15:0] t;
        h = s >>> 2;
        t = 16'(h);
        return int'(t);
`endif
    endfunction

    function automatic int rand_val();
        case ($urandom_range(0, 5))
            0:       return 32767;
            1:       return -32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.mix_ready) begin
            check("pending_expect", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("mix_out", bus.mix_out, e.val);
                check("timeout_err", bus.timeout_err, e.terr);
                check("latency", cyc, e.cyc);
                last_out = e.val;
            end
        end
    end

    task automatic set_ch(input int n, input logic rdy, input int v);
        case (n)
            0: begin bus.harm0_ready = rdy; bus.harm0_in = 16'(v); end
            1: begin bus.harm1_ready = rdy; bus.harm1_in = 16'(v); end
            default: begin bus.harm2_ready = rdy; bus.harm2_in = 16'(v); end
        endcase
    endtask

    task automatic set_txn(input logic [2:0] en, input int f0, input int f1, input int f2,
                           input int v0, input int v1, input int v2);
        en_m = en;
        fd[0] = f0; fd[1] = f1; fd[2] = f2;
        fv[0] = v0; fv[1] = v1; fv[2] = v2;
        for (int n = 0; n < 3; n++) begin
            sd[n] = 0;
            sv[n] = 0;
        end
    endtask

    // Issues the request; the model predicts the completion edge from the pulse schedule.
    task automatic start_mix(input bit expect_out);
        exp_t e;
        bit   complete;
        int   emax;
        int   done_cyc;
        int   s;
        @(posedge clk); #1;
        bus.harm_en = en_m;
        bus.generate_next_sample = 1'b1;
        g_cyc = cyc + 1;
        complete = 1'b1;
        emax = 1;
        for (int n = 0; n < 3; n++) begin
            if (en_m[n]) begin
                if (fd[n] == 0) complete = 1'b0;
                else if (fd[n] > emax) emax = fd[n];
            end
        end
        done_cyc = complete ? g_cyc + emax : g_cyc + TIMEOUT;
        s = 0;
        for (int n = 0; n < 3; n++) begin
            if (en_m[n] && fd[n] != 0)
                s += (sd[n] != 0 && g_cyc + sd[n] <= done_cyc) ? sv[n] : fv[n];
        end
        if (expect_out) begin
            e.val  = scale(s);
            e.terr = !complete;
            e.cyc  = done_cyc + 2;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.generate_next_sample = 1'b0;
    endtask

    task automatic drive_pulses(input int gen_at);
        for (int k = 1; k <= 10; k++) begin
            for (int n = 0; n < 3; n++) begin
                if (fd[n] == k)      set_ch(n, 1'b1, fv[n]);
                else if (sd[n] == k) set_ch(n, 1'b1, sv[n]);
                else                 set_ch(n, 1'b0, rand_val());
            end
            if (k == gen_at) bus.generate_next_sample = 1'b1;
            @(posedge clk); #1;
            bus.generate_next_sample = 1'b0;
            if (k == gen_at)     check("overrun", bus.overrun, 1);
            if (k == gen_at + 1) check("overrun_clear", bus.overrun, 0);
        end
        for (int n = 0; n < 3; n++) set_ch(n, 1'b0, 0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 120 && exp_q.size() > 0; i++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        if (exp_q.size() > 0) exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_mix();
        start_mix(1'b1);
        drive_pulses(0);
        wait_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.play_enable = 1'b1;
        bus.note_done = 1'b0;
        bus.generate_next_sample = 1'b0;
        bus.harm_en = 3'b000;
        for (int n = 0; n < 3; n++) set_ch(n, 1'b0, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mix_out", bus.mix_out, 0);
        check("rst_mix_ready", bus.mix_ready, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        check("rst_overrun", bus.overrun, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        set_txn(3'b111, 1, 1, 1, 1000, 2000, 3000);     run_mix();
        set_txn(3'b111, 1, 1, 1, 32767, 32767, 32767);  run_mix();
        set_txn(3'b111, 2, 1, 3, -32768, -32768, -32768); run_mix();
        set_txn(3'b101, 1, 0, 1, 400, 1234, 400);       run_mix();
        set_txn(3'b111, 1, 1, 0, 100, 200, 300);        run_mix();
        set_txn(3'b000, 1, 2, 3, 500, 600, 700);        run_mix();

        // note_done during COLLECT clears the output and discards the mix
        set_txn(3'b111, 3, 3, 3, 5, 6, 7);
        start_mix(1'b0);
        bus.note_done = 1'b1;
        @(posedge clk); #1;
        bus.note_done = 1'b0;
        check("note_done_clear", bus.mix_out, 0);
        last_out = 0;
        drive_pulses(0);
        repeat (4) @(posedge clk);
        #1;
        set_txn(3'b011, 2, 1, 0, 40, 80, 0);            run_mix();

        // request during SUM: overrun pulse, exactly one mix_ready
        set_txn(3'b111, 1, 1, 1, 10, 20, 30);
        start_mix(1'b1);
        drive_pulses(2);
        wait_drain();

        // pause mid-COLLECT and a request while paused both leave mix_out frozen
        set_txn(3'b111, 2, 2, 2, 900, 900, 900);
        start_mix(1'b0);
        bus.play_enable = 1'b0;
        drive_pulses(0);
        check("pause_frozen", bus.mix_out, last_out);
        start_mix(1'b0);
        drive_pulses(0);
        check("pause_gen_frozen", bus.mix_out, last_out);
        bus.play_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // asynchronous reset between edges while collecting
        set_txn(3'b111, 1, 5, 5, 8000, 8000, 8000);
        start_mix(1'b0);
        set_ch(0, 1'b1, 8000);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("areset_mix_out", bus.mix_out, 0);
        check("areset_mix_ready", bus.mix_ready, 0);
        check("areset_overrun", bus.overrun, 0);
        set_ch(0, 1'b0, 0);
        last_out = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        set_txn(3'b110, 0, 1, 2, 0, -3000, -5000);       run_mix();

        for (int t = 0; t < 60; t++) begin
            en_m = 3'($urandom_range(0, 7));
            for (int n = 0; n < 3; n++) begin
                fd[n] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
                sd[n] = (fd[n] != 0 && $urandom_range(0, 2) == 0) ? fd[n] + int'($urandom_range(1, 3)) : 0;
                fv[n] = rand_val();
                sv[n] = rand_val();
            end
            run_mix();
        end

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
